// File: rtl/bsn_pipe.sv
// Pipelined bitonic sorting network: one compare stage per register, direction travels with each vector.
// Build option: define BSN_PIPE_SIGNED_EN for two's-complement keys; unsigned keys otherwise.
module bsn_pipe #(
    parameter  int DATA_WIDTH = 32,
    parameter  int LOG_N      = 3,
    localparam int N_INPUTS   = 2 ** LOG_N
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           direction,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] data_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_INPUTS*DATA_WIDTH-1:0] data_out,
    output logic                           busy
);

    localparam int S  = LOG_N * (LOG_N + 1) / 2;
    localparam int VW = N_INPUTS * DATA_WIDTH;
    // The last stage's direction is never consumed, so only the first S-1 stages carry it.
    localparam int DW = (S > 1) ? S - 1 : 1;

    // Returns k (want_j=0) or j (want_j=1) of stage s in the k-major, j-descending order.
    function automatic int stage_param(input int s, input bit want_j);
        int idx;
        int res;
        idx = 0;
        res = 0;
        for (int p = 1; p <= LOG_N; p++) begin
            for (int q = p - 1; q >= 0; q--) begin
                if (idx == s) res = want_j ? (1 << q) : (1 << p);
                idx++;
            end
        end
        return res;
    endfunction

    function automatic logic key_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
`ifdef BSN_PIPE_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    // Strict compares keep equal keys in place. For k == N_INPUTS, (i & k) is 0 for every lane.
    function automatic logic [VW-1:0] cmp_stage(input logic [VW-1:0] d, input logic dir,
                                                input int k, input int j);
        logic [VW-1:0]         r;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic                  lo_min;
        int                    l;
        r = d;
        for (int i = 0; i < N_INPUTS; i++) begin
            if ((i & j) == 0) begin
                l      = i | j;
                a      = d[i*DATA_WIDTH +: DATA_WIDTH];
                b      = d[l*DATA_WIDTH +: DATA_WIDTH];
                lo_min = ((i & k) == 0) ^ dir;
                if (lo_min ? key_gt(a, b) : key_gt(b, a)) begin
                    r[i*DATA_WIDTH +: DATA_WIDTH] = b;
                    r[l*DATA_WIDTH +: DATA_WIDTH] = a;
                end
            end
        end
        return r;
    endfunction

    logic                  adv;
    logic [S-1:0]          valid_q, valid_d;
    logic [DW-1:0]         dir_q, dir_d;
    logic [S-1:0][VW-1:0]  data_q, data_d;

    assign adv       = en && (!out_valid || out_ready);
    assign in_ready  = adv;
    assign out_valid = valid_q[S-1];
    assign data_out  = data_q[S-1];
    assign busy      = |valid_q;

    for (genvar s = 0; s < S; s++) begin : g_stage
        localparam int K = stage_param(s, 1'b0);
        localparam int J = stage_param(s, 1'b1);
        if (s == 0) begin : g_first
            assign data_d[s] = cmp_stage(data_in, direction, K, J);
        end else begin : g_rest
            assign data_d[s] = cmp_stage(data_q[s-1], dir_q[s-1], K, J);
        end
    end

    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        dir_d   = dir_q;
        if (adv) begin
            valid_d[0] = in_valid;
            dir_d[0]   = direction;
            for (int s = 1; s < S; s++) valid_d[s] = valid_q[s-1];
            for (int s = 1; s < DW; s++) dir_d[s] = dir_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every stage samples the pre-edge value of its neighbour.
        if (rst) begin
            valid_q <= '0;
            dir_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            dir_q   <= dir_d;
            if (adv) data_q <= data_d;
        end
    end

endmodule

// File: tb/tb_bsn_pipe.sv
// Scoreboard bench for bsn_pipe (LOG_N=3, DATA_WIDTH=8, six stages); honours BSN_PIPE_SIGNED_EN.
module tb_bsn_pipe;

    localparam int W     = 8;
    localparam int LOG_N = 3;
    localparam int S     = 6;
    localparam int NW    = 64;

    logic          clk = 1'b0;
    logic          rst, en, in_valid, in_ready, direction;
    logic          out_valid, out_ready, busy;
    logic [NW-1:0] data_in, data_out;

    always #5 clk = ~clk;

    bsn_pipe #(.DATA_WIDTH(W), .LOG_N(LOG_N)) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready), .direction(direction), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy)
    );

    typedef struct {
        logic [NW-1:0] vec;
        int            acc;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    bit            chk_lat = 1'b1;
    logic [NW-1:0] exp_cur;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NW-1:0] pk(input int l0, input int l1, input int l2, input int l3,
                                         input int l4, input int l5, input int l6, input int l7);
        return {8'(l7), 8'(l6), 8'(l5), 8'(l4), 8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: output compared against queue front every valid cycle, popped on transfer;
    // accepted inputs push the expectation the driver attached to them.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_output: got %h, expected no output", data_out);
                end else begin
                    check("data_out", data_out, sb[0].vec);
                    if (out_ready && en) begin
                        if (chk_lat) check("latency", 64'(cyc - sb[0].acc), 64'(S));
                        void'(sb.pop_front());
                    end
                end
            end
            if (in_valid && in_ready && en) sb.push_back('{exp_cur, cyc});
        end
    end

    task automatic send(input logic [NW-1:0] d, input logic dir, input logic [NW-1:0] e);
        int t;
        data_in   = d;
        direction = dir;
        exp_cur   = e;
        in_valid  = 1'b1;
        t = 0;
        @(negedge clk);
        while (!(in_ready && en) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected acceptance");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", 64'(sb.size()), 64'd0);
        check("drain_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        direction = 1'b0; data_in = '0; exp_cur = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_data_out", data_out, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single ascending vector, latency checked by the monitor.
        send(pk(7,3,5,1,6,0,4,2), 1'b0, pk(0,1,2,3,4,5,6,7));
        drain();

        // Back-to-back mixed directions.
        send(pk(7,3,5,1,6,0,4,2), 1'b0, pk(0,1,2,3,4,5,6,7));
        send(pk(1,2,3,4,5,6,7,8), 1'b1, pk(8,7,6,5,4,3,2,1));
        drain();

        // Duplicates stay put; signedness depends on the build.
        send(pk(5,5,5,5,0,0,255,255), 1'b0, pk(0,0,5,5,5,5,255,255));
`ifdef BSN_PIPE_SIGNED_EN
        send(pk(8'h80,8'h7F,0,1,2,3,4,5), 1'b0, pk(8'h80,0,1,2,3,4,5,8'h7F));
`else
        send(pk(8'h80,8'h7F,0,1,2,3,4,5), 1'b0, pk(0,1,2,3,4,5,8'h7F,8'h80));
`endif
        drain();

        // Backpressure: 8 vectors with out_ready low for 10 cycles.
        chk_lat = 1'b0;
        fork
            begin
                for (int n = 0; n < 8; n++) begin
                    int b;
                    b = 10 * n;
                    if (n % 2 == 0)
                        send(pk(7+b,3+b,5+b,1+b,6+b,0+b,4+b,2+b), 1'b0,
                             pk(b,1+b,2+b,3+b,4+b,5+b,6+b,7+b));
                    else
                        send(pk(7+b,3+b,5+b,1+b,6+b,0+b,4+b,2+b), 1'b1,
                             pk(7+b,6+b,5+b,4+b,3+b,2+b,1+b,b));
                end
            end
            begin
                out_ready = 1'b0;
                repeat (9) @(posedge clk);
                @(negedge clk);
                check("stall_out_valid", 64'(out_valid), 64'd1);
                check("stall_in_ready", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Global enable pause mid-stream.
        fork
            begin
                send(pk(9,8,7,6,5,4,3,2), 1'b0, pk(2,3,4,5,6,7,8,9));
                send(pk(0,20,10,30,0,20,10,30), 1'b1, pk(30,30,20,20,10,10,0,0));
                send(pk(1,1,1,1,1,1,1,0), 1'b0, pk(0,1,1,1,1,1,1,1));
            end
            begin
                @(posedge clk);
                #1 en = 1'b0;
                repeat (3) @(posedge clk);
                #1 en = 1'b1;
            end
        join
        drain();

        // Reset mid-flight: in-flight vectors must vanish.
        chk_lat = 1'b1;
        send(pk(7,3,5,1,6,0,4,2), 1'b0, pk(0,1,2,3,4,5,6,7));
        send(pk(1,2,3,4,5,6,7,8), 1'b1, pk(8,7,6,5,4,3,2,1));
        send(pk(5,5,5,5,0,0,255,255), 1'b0, pk(0,0,5,5,5,5,255,255));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            check("post_reset_out_valid", 64'(out_valid), 64'd0);
            check("post_reset_busy", 64'(busy), 64'd0);
        end
        @(posedge clk);
        #1;
        send(pk(4,4,3,3,2,2,1,1), 1'b1, pk(4,4,3,3,2,2,1,1));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bsn_pipe.md
BSN_PIPE -- requirements
Module: bsn_pipe

Interface
REQ-001 The block SHALL have these parameters:
- DATA_WIDTH, 32, bits per key.
- LOG_N, 3, log2 of the lane count, legal range 1..6.
- N_INPUTS, 2**LOG_N, lane count; derived, SHALL NOT be overridden.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; when 0, all state holds.
- in_valid  in  1  input vector offered.
- in_ready  out  1  block can accept the input vector.
- direction  in  1  per-vector sort order; 0 = ascending (lane 0 smallest), 1 = descending.
- data_in  in  N_INPUTS*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  sorted vector present.
- out_ready  in  1  downstream accepts the output vector.
- data_out  out  N_INPUTS*DATA_WIDTH  sorted lanes, same packing as data_in.
- busy  out  1  at least one pipeline stage holds a valid vector.
REQ-003 The block SHALL have one clock domain only; reset is synchronous and active-high.

Function
REQ-004 The block SHALL implement the full bitonic network with S = LOG_N*(LOG_N+1)/2 compare stages. Stage order is k = 2,4,..,N_INPUTS, then j = k/2 down to 1.
REQ-005 In stage (k,j), lanes i and l = i XOR j with i < l SHALL be compared. Lane i receives the smaller key when ((i AND k)==0) XOR direction_of_vector, and the larger key otherwise. For k = N_INPUTS, (i AND k) is taken as 0.
REQ-006 Each stage SHALL end in a register holding the lane data, a valid bit and that vector's direction bit. Direction SHALL travel with its vector, so mixed orders in flight are each sorted correctly.
REQ-007 Equal keys SHALL NOT be swapped.
REQ-008 Latency SHALL be exactly S cycles from the accepting edge (in_valid && in_ready && en) to out_valid.
REQ-009 Throughput SHALL be one vector per cycle while out_ready=1 and en=1.
REQ-010 The pipeline advance condition SHALL be adv = en && (!out_valid || out_ready).
- When adv=0, every stage register and valid bit holds.
- When adv=1, every stage shifts one place; stage 0 loads data_in, with valid = in_valid.
REQ-011 in_ready SHALL equal adv, combinationally.
- in_valid, data_in and direction SHALL be ignored when in_ready=0.
REQ-012 Bubbles SHALL propagate as valid=0. Stage data under valid=0 is don't-care but SHALL be deterministic (hold or load data_in).
REQ-013 out_valid and data_out SHALL be driven directly from the last stage register.
- Once out_valid=1, data_out SHALL stay stable until out_valid && out_ready && en.
REQ-014 busy SHALL be the OR of all stage valid bits.
REQ-015 When out_ready=1 and out_valid=1 in the same cycle that a new vector is offered, both the output transfer and the input acceptance SHALL occur.

Reset
REQ-016 On a rising clk edge with rst=1, all stage valid bits SHALL clear to 0. rst SHALL take priority over en.
REQ-017 During and after reset: out_valid=0, busy=0, and data_out=0 (stage data registers clear to 0).
REQ-018 Reset mid-operation SHALL discard all in-flight vectors; none SHALL appear at the output afterwards.
REQ-019 in_ready SHALL follow REQ-011 during reset; a vector presented in a reset cycle is not accepted.

Configuration
REQ-020 Macro BSN_PIPE_SIGNED_EN selects the comparison type:
- Defined: every comparator treats keys as two's-complement signed values.
- Undefined: every comparator treats keys as unsigned values.
- The interface and latency SHALL be identical in both builds.

Verification (LOG_N=3, DATA_WIDTH=8, S=6)
REQ-021 Single ascending vector: lanes 0..7 = {7,3,5,1,6,0,4,2}, direction=0, out_ready=1. Expected: out_valid exactly 6 cycles after acceptance, data_out lanes = {0,1,2,3,4,5,6,7}.
REQ-022 Back-to-back mixed order: vector A {7,3,5,1,6,0,4,2} with dir=0, then vector B {1,2,3,4,5,6,7,8} with dir=1, on consecutive cycles. Expected: consecutive outputs {0..7} then {8,7,6,5,4,3,2,1}.
REQ-023 Backpressure: hold out_ready=0 for 10 cycles while streaming 8 vectors. Expected:
- in_ready drops once the output is valid and stalled.
- No vector is lost or duplicated.
- data_out is stable throughout the stall.
REQ-024 Duplicates: {5,5,5,5,0,0,255,255}, dir=0. Expected: {0,0,5,5,5,5,255,255}.
REQ-025 Signedness: {8'h80,8'h7F,0,1,2,3,4,5}, dir=0. Expected:
- With BSN_PIPE_SIGNED_EN: lane 0 = 8'h80, lane 7 = 8'h7F.
- Without it: lane 0 = 0, lane 7 = 8'h80.
REQ-026 Reset mid-flight: accept 3 vectors, assert rst for 1 cycle at cycle 2. Expected: out_valid=0 and busy=0 for the next 8 cycles; no stale output.
